ml_spi_cmd_decoder: RTL and testbench

- Downstream consumer of the SPI peripheral's received-byte stream (rx byte plus one-cycle data-valid pulse) in the ML model harness.
- Assembles fixed 7-byte command frames, checks them, and issues write, start, read and status actions to the ML model core.
- Produces the reply byte plus tx data-valid pulse that the SPI peripheral serialises onto POCI during the next transfer.

---
 rtl/ml_spi_pkg.sv | 50 +++++
 rtl/ml_spi_cmd_decoder_queue.sv | 49 ++++
 rtl/ml_spi_cmd_decoder.sv | 231 +++++++++++++++++++++++
 tb/tb_ml_spi_cmd_decoder.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ml_spi_pkg.sv
// ml_spi_pkg: shared constants, state type and helpers for the SPI command
// decoder of the ML model harness.
//   - opcode constants for the four supported commands
//   - frame length and the byte count at which a frame is evaluated
//   - decoder state enum
//   - bit positions inside the STATUS reply byte
//   - checksum and status-byte helper functions
package ml_spi_pkg;

   localparam logic [7:0] OP_WRITE  = 8'h01;
   localparam logic [7:0] OP_START  = 8'h02;
   localparam logic [7:0] OP_READ   = 8'h03;
   localparam logic [7:0] OP_STATUS = 8'h04;

   localparam int         FRAME_LEN = 7;
   // Count value at which the next received byte is the checksum byte
   localparam logic [2:0] CHK_POS   = 3'(FRAME_LEN - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int ST_BUSY  = 7;
   localparam int ST_VALID = 6;
   localparam int ST_ABORT = 2;
   localparam int ST_CHK   = 1;
   localparam int ST_CMD   = 0;

   // Running frame checksum: plain XOR of every byte seen so far
   function automatic logic [7:0] chk_accum(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

   // Assemble the STATUS reply byte from the live and sticky flags
   function automatic logic [7:0] status_byte(input logic busy, input logic valid,
                                              input logic err_abort, input logic err_chk,
                                              input logic err_cmd);
      logic [7:0] s;
      s           = 8'h00;
      s[ST_BUSY]  = busy;
      s[ST_VALID] = valid;
      s[ST_ABORT] = err_abort;
      s[ST_CHK]   = err_chk;
      s[ST_CMD]   = err_cmd;
      return s;
   endfunction

endpackage

// File: rtl/ml_spi_cmd_decoder_queue.sv
// ml_resp_queue: up to 4-byte reply queue replayed least-significant byte first.
//   clk, rst     : clock, async active-high reset
//   i_flush      : drop all queued bytes (highest priority)
//   i_load       : parallel load i_data with i_len valid bytes
//   i_pop        : advance to the next byte
//   o_byte       : byte at the head of the queue
//   o_empty      : no bytes queued
//   o_last       : exactly one byte queued
module ml_resp_queue (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_flush,
   input  logic        i_load,
   input  logic [2:0]  i_len,
   input  logic [31:0] i_data,
   input  logic        i_pop,
   output logic [7:0]  o_byte,
   output logic        o_empty,
   output logic        o_last
);

   logic [31:0] r_data;
   logic [2:0]  r_cnt;

   // Queue storage: shift right one byte per pop so the head is always [7:0]
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data <= 32'h0000_0000;
         r_cnt  <= 3'd0;
      end else if (i_flush) begin
         r_data <= 32'h0000_0000;
         r_cnt  <= 3'd0;
      end else if (i_load) begin
         r_data <= i_data;
         r_cnt  <= i_len;
      end else if (i_pop && (r_cnt != 3'd0)) begin
         r_data <= {8'h00, r_data[31:8]};
         r_cnt  <= r_cnt - 3'd1;
      end else begin
         r_data <= r_data;
         r_cnt  <= r_cnt;
      end
   end

   assign o_byte  = r_data[7:0];
   assign o_empty = (r_cnt == 3'd0);
   assign o_last  = (r_cnt == 3'd1);

endmodule

// File: rtl/ml_spi_cmd_decoder.sv
// ml_spi_cmd_decoder: assembles 7-byte SPI command frames (CMD, ADDR, DATA[4]
// LSB first, CHK = XOR of the first six), executes WRITE/START/READ/STATUS and
// returns one reply byte per received byte, one cycle after it.
//   clk, rst                   : clock, async active-high reset
//   i_rx_dv, i_rx_byte, i_cs_n : received byte stream and chip select
//   o_tx_dv, o_tx_byte         : reply byte for the next SPI transfer
//   o_wr_en, o_wr_addr/data    : register-file write strobe and payload
//   o_start                    : inference start pulse
//   i_busy, i_result_valid, i_result : model status and result word
module ml_spi_cmd_decoder
   import ml_spi_pkg::*;
#(
   parameter int         ADDR_W    = 8,
   parameter logic [7:0] ACK_BYTE  = 8'hAC,
   parameter logic [7:0] NAK_BYTE  = 8'hEE,
   parameter logic [7:0] FILL_BYTE = 8'h00
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_rx_dv,
   input  logic [7:0]        i_rx_byte,
   input  logic              i_cs_n,
   output logic              o_tx_dv,
   output logic [7:0]        o_tx_byte,
   output logic              o_wr_en,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [31:0]       o_wr_data,
   output logic              o_start,
   input  logic              i_busy,
   input  logic              i_result_valid,
   input  logic [31:0]       i_result
);

   state_t      r_state, w_state_nxt;
   logic [2:0]  r_count;
   logic [7:0]  r_chk, r_cmd, r_addr;
   logic [31:0] r_data;
   logic        r_err_chk, r_err_cmd, r_err_abort;

   logic        w_abort, w_accept, w_eval, w_chk_ok, w_to_resp;
   logic [7:0]  w_tx_byte_nxt;
   logic        w_wr_en_nxt, w_start_nxt;
   logic        w_q_load, w_q_pop, w_q_empty, w_q_last;
   logic [2:0]  w_q_len;
   logic [31:0] w_q_data;
   logic [7:0]  w_q_byte;
   logic        w_set_chk, w_set_cmd, w_set_abort, w_clr_flags;

   // Chip select only aborts an active frame/reply; when it does, a byte in
   // the same cycle is dropped.
   assign w_abort     = i_cs_n && (r_state != IDLE);
   assign w_accept    = i_rx_dv && !w_abort;
   assign w_eval      = w_accept && (r_state == RECV) && (r_count == CHK_POS);
   assign w_chk_ok    = (r_chk == i_rx_byte);
   assign w_to_resp   = w_chk_ok && ((r_cmd == OP_READ) || (r_cmd == OP_STATUS));
   assign w_q_pop     = w_accept && (r_state == RESP);
   assign w_set_abort = w_abort && (r_state == RECV) && (r_count != 3'd0);

   ml_resp_queue u_queue (
      .clk     (clk),
      .rst     (rst),
      .i_flush (w_abort),
      .i_load  (w_q_load),
      .i_len   (w_q_len),
      .i_data  (w_q_data),
      .i_pop   (w_q_pop),
      .o_byte  (w_q_byte),
      .o_empty (w_q_empty),
      .o_last  (w_q_last)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) w_state_nxt = RECV;
            else          w_state_nxt = IDLE;
         end
         RECV: begin
            if (w_abort)     w_state_nxt = IDLE;
            else if (w_eval) w_state_nxt = w_to_resp ? RESP : IDLE;
            else             w_state_nxt = RECV;
         end
         RESP: begin
            // An empty queue here can only follow corruption; fall back to IDLE
            if (w_abort || w_q_empty)     w_state_nxt = IDLE;
            else if (w_accept && w_q_last) w_state_nxt = IDLE;
            else                           w_state_nxt = RESP;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Output decode: reply byte, action strobes, queue load and flag updates
   always_comb begin
      w_tx_byte_nxt = FILL_BYTE;
      w_wr_en_nxt   = 1'b0;
      w_start_nxt   = 1'b0;
      w_q_load      = 1'b0;
      w_q_len       = 3'd0;
      w_q_data      = 32'h0000_0000;
      w_set_chk     = 1'b0;
      w_set_cmd     = 1'b0;
      w_clr_flags   = 1'b0;
      if (w_eval) begin
         if (!w_chk_ok) begin
            w_tx_byte_nxt = NAK_BYTE;
            w_set_chk     = 1'b1;
         end else begin
            case (r_cmd)
               OP_WRITE: begin
                  w_wr_en_nxt   = 1'b1;
                  w_tx_byte_nxt = ACK_BYTE;
               end
               OP_START: begin
                  if (i_busy) begin
                     w_tx_byte_nxt = NAK_BYTE;
                  end else begin
                     w_start_nxt   = 1'b1;
                     w_tx_byte_nxt = ACK_BYTE;
                  end
               end
               OP_READ: begin
                  w_tx_byte_nxt = ACK_BYTE;
                  w_q_load      = 1'b1;
                  w_q_len       = 3'd4;
                  w_q_data      = i_result;
               end
               OP_STATUS: begin
                  w_tx_byte_nxt = ACK_BYTE;
                  w_q_load      = 1'b1;
                  w_q_len       = 3'd1;
                  w_q_data      = {24'h00_0000, status_byte(i_busy, i_result_valid,
                                     r_err_abort, r_err_chk, r_err_cmd)};
                  w_clr_flags   = 1'b1;
               end
               default: begin
                  w_tx_byte_nxt = NAK_BYTE;
                  w_set_cmd     = 1'b1;
               end
            endcase
         end
      end else if (r_state == RESP) begin
         w_tx_byte_nxt = w_q_byte;
      end else begin
         w_tx_byte_nxt = FILL_BYTE;
      end
   end

   // Frame assembly: byte counter, running checksum, command/address/data capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= 3'd0;
         r_chk   <= 8'h00;
         r_cmd   <= 8'h00;
         r_addr  <= 8'h00;
         r_data  <= 32'h0000_0000;
      end else if (w_abort) begin
         r_count <= 3'd0;
         r_chk   <= 8'h00;
      end else if (w_accept) begin
         case (r_state)
            IDLE: begin
               r_cmd   <= i_rx_byte;
               r_chk   <= chk_accum(8'h00, i_rx_byte);
               r_count <= 3'd1;
            end
            RECV: begin
               if (w_eval) begin
                  r_count <= 3'd0;
                  r_chk   <= 8'h00;
               end else begin
                  r_count <= r_count + 3'd1;
                  r_chk   <= chk_accum(r_chk, i_rx_byte);
                  // DATA arrives LSB first, so shift each new byte in at the top
                  if (r_count == 3'd1) r_addr <= i_rx_byte;
                  else                 r_data <= {i_rx_byte, r_data[31:8]};
               end
            end
            default: r_count <= r_count;
         endcase
      end else begin
         r_count <= r_count;
      end
   end

   // Sticky error flags: a flag being set wins over a STATUS clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err_chk   <= 1'b0;
         r_err_cmd   <= 1'b0;
         r_err_abort <= 1'b0;
      end else begin
         r_err_chk   <= w_set_chk   | (r_err_chk   & ~w_clr_flags);
         r_err_cmd   <= w_set_cmd   | (r_err_cmd   & ~w_clr_flags);
         r_err_abort <= w_set_abort | (r_err_abort & ~w_clr_flags);
      end
   end

   // Registered outputs; write address/data hold between strobes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_tx_dv   <= 1'b0;
         o_tx_byte <= 8'h00;
         o_wr_en   <= 1'b0;
         o_wr_addr <= '0;
         o_wr_data <= 32'h0000_0000;
         o_start   <= 1'b0;
      end else begin
         o_tx_dv <= w_accept;
         o_wr_en <= w_wr_en_nxt;
         o_start <= w_start_nxt;
         if (w_accept) o_tx_byte <= w_tx_byte_nxt;
         if (w_wr_en_nxt) begin
            o_wr_addr <= ADDR_W'(r_addr);
            o_wr_data <= r_data;
         end
      end
   end

endmodule

// File: tb/tb_ml_spi_cmd_decoder.sv
module tb_ml_spi_cmd_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_rx_dv, i_cs_n, i_busy, i_result_valid;
   logic [7:0]  i_rx_byte;
   logic [31:0] i_result;
   logic        o_tx_dv, o_wr_en, o_start;
   logic [7:0]  o_tx_byte, o_wr_addr;
   logic [31:0] o_wr_data;

   int n_checks = 0;
   int n_fail   = 0;
   bit rand_on  = 1'b0;

   always #5 clk = ~clk;

   ml_spi_cmd_decoder dut (
      .clk(clk), .rst(rst), .i_rx_dv(i_rx_dv), .i_rx_byte(i_rx_byte), .i_cs_n(i_cs_n),
      .o_tx_dv(o_tx_dv), .o_tx_byte(o_tx_byte), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
      .o_wr_data(o_wr_data), .o_start(o_start), .i_busy(i_busy),
      .i_result_valid(i_result_valid), .i_result(i_result)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model (frame list + reply list) ----------------
   logic [7:0]  m_frame[$];
   logic [7:0]  m_resp[$];
   bit          m_err_chk, m_err_cmd, m_err_abort;
   bit          e_tx_dv, e_wr_en, e_start;
   logic [7:0]  e_tx_byte, e_wr_addr;
   logic [31:0] e_wr_data;

   task automatic model_eval(input logic [7:0] chk);
      logic [7:0]  x;
      logic [31:0] d;
      x = 8'h00;
      foreach (m_frame[k]) x = x ^ m_frame[k];
      d = {m_frame[5], m_frame[4], m_frame[3], m_frame[2]};
      if (x != chk) begin
         e_tx_byte = 8'hEE;
         m_err_chk = 1'b1;
      end else begin
         case (m_frame[0])
            8'h01: begin
               e_wr_en = 1'b1; e_wr_addr = m_frame[1]; e_wr_data = d; e_tx_byte = 8'hAC;
            end
            8'h02: begin
               if (i_busy) e_tx_byte = 8'hEE;
               else begin e_start = 1'b1; e_tx_byte = 8'hAC; end
            end
            8'h03: begin
               e_tx_byte = 8'hAC;
               for (int k = 0; k < 4; k++) m_resp.push_back(i_result[8*k +: 8]);
            end
            8'h04: begin
               e_tx_byte = 8'hAC;
               m_resp.push_back({i_busy, i_result_valid, 3'b000, m_err_abort, m_err_chk, m_err_cmd});
               m_err_abort = 1'b0; m_err_chk = 1'b0; m_err_cmd = 1'b0;
            end
            default: begin
               e_tx_byte = 8'hEE;
               m_err_cmd = 1'b1;
            end
         endcase
      end
      m_frame.delete();
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_frame.delete(); m_resp.delete();
         m_err_chk = 1'b0; m_err_cmd = 1'b0; m_err_abort = 1'b0;
         e_tx_dv = 1'b0; e_wr_en = 1'b0; e_start = 1'b0;
         e_tx_byte = 8'h00; e_wr_addr = 8'h00; e_wr_data = 32'h0;
      end else begin
         e_tx_dv = 1'b0; e_wr_en = 1'b0; e_start = 1'b0;
         if (i_cs_n && (m_frame.size() > 0 || m_resp.size() > 0)) begin
            if (m_frame.size() > 0) m_err_abort = 1'b1;
            m_frame.delete();
            m_resp.delete();
         end else if (i_rx_dv) begin
            e_tx_dv = 1'b1;
            if (m_resp.size() > 0) begin
               e_tx_byte = m_resp.pop_front();
            end else if (m_frame.size() < 6) begin
               m_frame.push_back(i_rx_byte);
               e_tx_byte = 8'h00;
            end else begin
               model_eval(i_rx_byte);
            end
         end
      end
   end

   // Per-cycle comparison of DUT against the model, away from the active edge
   always @(negedge clk) begin
      check("tx_dv", 32'(o_tx_dv), 32'(e_tx_dv));
      check("wr_en", 32'(o_wr_en), 32'(e_wr_en));
      check("start", 32'(o_start), 32'(e_start));
      check("wr_addr", 32'(o_wr_addr), 32'(e_wr_addr));
      check("wr_data", o_wr_data, e_wr_data);
      if (e_tx_dv) check("tx_byte", 32'(o_tx_byte), 32'(e_tx_byte));
   end

   // Monitor for the hand-computed literal checks
   logic [7:0] tx_log[$];
   logic [7:0] exp_q[$];
   int         wr_cnt = 0;
   int         start_cnt = 0;
   always @(negedge clk) begin
      if (o_tx_dv) tx_log.push_back(o_tx_byte);
      if (o_wr_en) wr_cnt++;
      if (o_start) start_cnt++;
   end

   task automatic check_log(input string name);
      check({name, "_len"}, 32'(tx_log.size()), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && k < tx_log.size(); k++)
         check(name, 32'(tx_log[k]), 32'(exp_q[k]));
   endtask

   task automatic settle();
      repeat (3) @(negedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   task automatic send_byte(input logic [7:0] b, input int gap);
      @(negedge clk);
      i_rx_dv = 1'b1; i_rx_byte = b;
      if (rand_on) begin
         i_busy = 1'($urandom_range(0, 1));
         i_result_valid = 1'($urandom_range(0, 1));
         i_result = $urandom;
      end
      @(negedge clk);
      i_rx_dv = 1'b0; i_rx_byte = 8'($urandom);
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] cmd, input logic [7:0] addr,
                             input logic [31:0] data, input logic [7:0] chk_flip);
      logic [7:0] b[7];
      b[0] = cmd; b[1] = addr;
      for (int k = 0; k < 4; k++) b[2+k] = data[8*k +: 8];
      b[6] = b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5] ^ chk_flip;
      for (int k = 0; k < 7; k++) send_byte(b[k], 0);
   endtask

   task automatic do_abort(input bit with_byte);
      @(negedge clk);
      i_cs_n = 1'b1;
      if (with_byte) begin i_rx_dv = 1'b1; i_rx_byte = 8'($urandom); end
      @(negedge clk);
      i_rx_dv = 1'b0;
      repeat (2) @(negedge clk);
      i_cs_n = 1'b0;
   endtask

   initial begin
      int w0, s0, dummies, abort_at, sel;
      logic [7:0] cmd, flip;
      logic [7:0] raw[7];

      rst = 1'b1; i_rx_dv = 1'b0; i_rx_byte = 8'h00; i_cs_n = 1'b0;
      i_busy = 1'b0; i_result_valid = 1'b0; i_result = 32'h0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_tx_dv", 32'(o_tx_dv), 32'h0);
      check("rst_wr_en", 32'(o_wr_en), 32'h0);
      check("rst_start", 32'(o_start), 32'h0);
      check("rst_wr_data", o_wr_data, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // WRITE 01 10 78 56 34 12, checksum of those six bytes is 0x19
      raw = '{8'h01, 8'h10, 8'h78, 8'h56, 8'h34, 8'h12, 8'h19};
      tx_log.delete();
      for (int k = 0; k < 7; k++) send_byte(raw[k], 1);
      settle();
      exp_q = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAC};
      check_log("write_tx");
      check("write_cnt", 32'(wr_cnt), 32'd1);
      check("write_addr", 32'(o_wr_addr), 32'h10);
      check("write_data", o_wr_data, 32'h1234_5678);

      // START idle then busy
      i_busy = 1'b0;
      send_frame(8'h02, 8'h00, 32'h0, 8'h00);
      settle();
      check("start_cnt", 32'(start_cnt), 32'd1);
      check("start_ack", 32'(tx_log[tx_log.size()-1]), 32'hAC);
      i_busy = 1'b1;
      send_frame(8'h02, 8'h00, 32'h0, 8'h00);
      settle();
      check("start_busy_cnt", 32'(start_cnt), 32'd1);
      check("start_busy_nak", 32'(tx_log[tx_log.size()-1]), 32'hEE);
      i_busy = 1'b0;

      // READ then four dummies, then a new frame is accepted
      i_result = 32'hDEAD_BEEF; i_result_valid = 1'b1;
      tx_log.delete();
      send_frame(8'h03, 8'h00, 32'h0, 8'h00);
      for (int k = 0; k < 4; k++) send_byte(8'h5A, 0);
      settle();
      exp_q = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAC, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      check_log("read_tx");
      send_frame(8'h01, 8'h33, 32'h0102_0304, 8'h00);
      settle();
      check("after_read_wr", 32'(wr_cnt), 32'd2);
      check("after_read_addr", 32'(o_wr_addr), 32'h33);

      // Bad-checksum WRITE, then two STATUS reads
      raw = '{8'h01, 8'h10, 8'h78, 8'h56, 8'h34, 8'h12, 8'h00};
      for (int k = 0; k < 7; k++) send_byte(raw[k], 0);
      settle();
      check("badchk_nak", 32'(tx_log[tx_log.size()-1]), 32'hEE);
      check("badchk_no_wr", 32'(wr_cnt), 32'd2);
      i_busy = 1'b0; i_result_valid = 1'b1;
      tx_log.delete();
      send_frame(8'h04, 8'h00, 32'h0, 8'h00);
      send_byte(8'h00, 0);
      send_frame(8'h04, 8'h00, 32'h0, 8'h00);
      send_byte(8'h00, 0);
      settle();
      exp_q = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAC, 8'h42,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAC, 8'h40};
      check_log("status_tx");

      // Abort after three bytes, then STATUS shows err_abort
      i_result_valid = 1'b0;
      w0 = wr_cnt;
      tx_log.delete();
      send_byte(8'h01, 0); send_byte(8'h10, 0); send_byte(8'h78, 0);
      do_abort(1'b0);
      send_frame(8'h04, 8'h00, 32'h0, 8'h00);
      send_byte(8'h00, 0);
      settle();
      exp_q = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAC, 8'h04};
      check_log("abort_tx");
      check("abort_no_wr", 32'(wr_cnt), 32'(w0));

      // Reset mid-frame, then a full frame
      send_byte(8'h01, 0); send_byte(8'h22, 0); send_byte(8'h0D, 0); send_byte(8'hF0, 0);
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check("mid_rst_wr_addr", 32'(o_wr_addr), 32'h0);
      check("mid_rst_wr_data", o_wr_data, 32'h0);
      check("mid_rst_tx_dv", 32'(o_tx_dv), 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      w0 = wr_cnt;
      send_frame(8'h01, 8'h22, 32'hCAFE_F00D, 8'h00);
      settle();
      check("rst_frame_wr", 32'(wr_cnt), 32'(w0 + 1));
      check("rst_frame_addr", 32'(o_wr_addr), 32'h22);
      check("rst_frame_data", o_wr_data, 32'hCAFE_F00D);

      // Randomized frames checked by the per-cycle compare
      rand_on = 1'b1;
      s0 = start_cnt;
      for (int it = 0; it < 250; it++) begin
         sel = $urandom_range(0, 9);
         if (sel < 3)      cmd = 8'h01;
         else if (sel < 5) cmd = 8'h02;
         else if (sel < 7) cmd = 8'h03;
         else if (sel < 9) cmd = 8'h04;
         else              cmd = 8'($urandom);
         flip = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
         abort_at = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 6) : 0;
         raw[0] = cmd; raw[1] = 8'($urandom);
         for (int k = 2; k < 6; k++) raw[k] = 8'($urandom);
         raw[6] = raw[0] ^ raw[1] ^ raw[2] ^ raw[3] ^ raw[4] ^ raw[5] ^ flip;
         for (int k = 0; k < 7; k++) begin
            if (abort_at != 0 && k == abort_at) begin
               do_abort(1'($urandom_range(0, 1)));
               break;
            end
            send_byte(raw[k], $urandom_range(0, 2));
         end
         if (abort_at == 0) begin
            dummies = (flip == 8'h00 && cmd == 8'h03) ? 4 :
                      (flip == 8'h00 && cmd == 8'h04) ? 1 : 0;
            if (dummies == 4 && $urandom_range(0, 7) == 0) begin
               send_byte(8'($urandom), 0);
               do_abort(1'($urandom_range(0, 1)));
            end else begin
               for (int k = 0; k < dummies; k++) send_byte(8'($urandom), $urandom_range(0, 2));
            end
         end
      end
      rand_on = 1'b0;
      settle();
      check("rand_saw_starts", 32'(start_cnt > s0), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
